// File: rtl/ann_load_sequencer.sv
// Streams 3*ROWS words into the ANN core matrices (input, hidden, output weights),
// waits SETTLE_CYCLES, then captures the core decision. Optional checksum: ANN_LOAD_SEQ_CHECKSUM_EN.
module ann_load_sequencer #(
    parameter int unsigned ROWS          = 29,
    parameter int unsigned DATA_W        = 21,
    parameter int unsigned ADR_W         = 5,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [1:0]        mat_sel,
    output logic [ADR_W-1:0]  adr,
    output logic [DATA_W-1:0] w_data,
    input  logic [2:0]        decision_in,
    output logic              busy,
    output logic              done,
    output logic [2:0]        result,
    output logic              result_valid
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE
    } state_t;

    localparam logic [ADR_W-1:0] LAST_ROW    = ADR_W'(ROWS - 1);
    localparam logic [7:0]       LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

    state_t              state, state_next;
    logic [1:0]          phase, phase_next;
    logic [ADR_W-1:0]    row, row_next;
    logic [7:0]          cnt, cnt_next;
    logic [1:0]          mat_sel_next;
    logic [ADR_W-1:0]    adr_next;
    logic [DATA_W-1:0]   w_data_next;
    logic                in_ready_next;
    logic                busy_next;
    logic                done_next;
    logic [2:0]          result_next;
    logic                result_valid_next;
    logic                beat;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
    logic [15:0]         checksum_next;
`endif

    assign beat = in_valid & in_ready;

    always_comb begin
        state_next        = state;
        phase_next        = phase;
        row_next          = row;
        cnt_next          = cnt;
        mat_sel_next      = 2'b11;
        adr_next          = adr;
        w_data_next       = w_data;
        busy_next         = busy;
        done_next         = 1'b0;
        result_next       = result;
        result_valid_next = result_valid;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
        checksum_next     = checksum;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    state_next        = LOAD;
                    phase_next        = '0;
                    row_next          = '0;
                    busy_next         = 1'b1;
                    result_valid_next = 1'b0;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
                    checksum_next     = '0;
`endif
                end
            end
            LOAD: begin
                if (beat) begin
                    mat_sel_next = phase;
                    adr_next     = row;
                    w_data_next  = in_data;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
                    checksum_next = checksum + in_data[15:0];
`endif
                    if (row == LAST_ROW) begin
                        row_next = '0;
                        if (phase == 2'd2) begin
                            state_next = SETTLE;
                            cnt_next   = '0;
                        end else begin
                            phase_next = phase + 2'd1;
                        end
                    end else begin
                        row_next = row + ADR_W'(1);
                    end
                end
            end
            SETTLE: begin
                // Outputs are registered on entry so done/result appear during CAPTURE.
                if (cnt == LAST_SETTLE) begin
                    state_next        = CAPTURE;
                    result_next       = decision_in;
                    result_valid_next = 1'b1;
                    done_next         = 1'b1;
                    busy_next         = 1'b0;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        in_ready_next = (state_next == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            row          <= '0;
            cnt          <= '0;
            mat_sel      <= 2'b11;
            adr          <= '0;
            w_data       <= '0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            row          <= row_next;
            cnt          <= cnt_next;
            mat_sel      <= mat_sel_next;
            adr          <= adr_next;
            w_data       <= w_data_next;
            in_ready     <= in_ready_next;
            busy         <= busy_next;
            done         <= done_next;
            result       <= result_next;
            result_valid <= result_valid_next;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
            checksum     <= checksum_next;
`endif
        end
    end

endmodule

// File: tb/tb_ann_load_sequencer.sv
// Directed bench for ann_load_sequencer: reset/idle, full loads with and without
// stalls, ignored start pulses, mid-run reset.
module tb_ann_load_sequencer;

    localparam int ROWS   = 29;
    localparam int DATA_W = 21;
    localparam int ADR_W  = 5;
    localparam int SETTLE = 2;
    localparam int TOTAL  = 3 * ROWS;

    logic              clk = 1'b0;
    logic              rst, start, in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        mat_sel;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] w_data;
    logic [2:0]        decision_in;
    logic              busy, done, result_valid;
    logic [2:0]        result;
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    int vectors     = 0;
    int miscompares = 0;

    ann_load_sequencer #(
        .ROWS(ROWS),
        .DATA_W(DATA_W),
        .ADR_W(ADR_W),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .mat_sel(mat_sel),
        .adr(adr),
        .w_data(w_data),
        .decision_in(decision_in),
        .busy(busy),
        .done(done),
        .result(result),
        .result_valid(result_valid)
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run: start at cycle 0, observe/drive each cycle until a few cycles past done.
    task automatic do_run(input bit gaps, input bit pokes, input logic [2:0] dec, input int exp_done);
        int cyc, accepted, nwr, wr_bad, gap_bad, rdy_bad, done_cnt, done_cyc, last_beat;
        bit beat_prev;
        logic [15:0] sum;
        decision_in = dec;
        start = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("rv_cleared_on_start", 32'(result_valid), 32'd0);
        cyc = 1; accepted = 0; nwr = 0; wr_bad = 0; gap_bad = 0; rdy_bad = 0;
        done_cnt = 0; done_cyc = -1; last_beat = -1; beat_prev = 1'b0; sum = '0;
        while (cyc < 1000 && (done_cyc < 0 || cyc < done_cyc + 3)) begin
            if ((mat_sel != 2'b11) !== beat_prev) gap_bad++;
            if (mat_sel != 2'b11) begin
                if (mat_sel !== 2'(nwr / ROWS) || adr !== ADR_W'(nwr % ROWS) ||
                    w_data !== DATA_W'(nwr + 1)) wr_bad++;
                nwr++;
            end
            if (in_ready !== (accepted < TOTAL)) rdy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                check("result_at_done", 32'(result), 32'(dec));
                check("rv_at_done", 32'(result_valid), 32'd1);
                check("busy_at_done", 32'(busy), 32'd0);
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
                check("checksum_at_done", 32'(checksum), 32'(sum));
`endif
            end
            start = (pokes && (cyc == 20 || cyc == last_beat + 1)) ? 1'b1 : 1'b0;
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = DATA_W'(accepted + 1);
            beat_prev = in_valid && (accepted < TOTAL);
            if (beat_prev) begin
                sum = sum + in_data[15:0];
                accepted++;
                if (accepted == TOTAL) last_beat = cyc;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("write_count", 32'(nwr), TOTAL);
        check("write_sequence_bad", 32'(wr_bad), 32'd0);
        check("write_only_after_beat_bad", 32'(gap_bad), 32'd0);
        check("in_ready_bad", 32'(rdy_bad), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_cyc), 32'(last_beat + 1 + SETTLE));
        if (exp_done > 0) check("done_cycle_abs", 32'(done_cyc), 32'(exp_done));
        check("result_held", 32'(result), 32'(dec));
        check("rv_held", 32'(result_valid), 32'd1);
        check("done_dropped", 32'(done), 32'd0);
        check("idle_no_write", 32'(mat_sel), 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int idle_bad;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; decision_in = '0;
        tick();
        tick();
        check("rst_mat_sel", 32'(mat_sel), 32'd3);
        check("rst_adr", 32'(adr), 32'd0);
        check("rst_w_data", 32'(w_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
`ifdef ANN_LOAD_SEQ_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif

        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 21'h1234;
        idle_bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready !== 1'b0 || mat_sel !== 2'b11 || busy !== 1'b0) idle_bad++;
        end
        check("idle_with_valid_bad", 32'(idle_bad), 32'd0);
        in_valid = 1'b0;

        do_run(1'b0, 1'b0, 3'd5, 3 * ROWS + SETTLE + 1);
        do_run(1'b1, 1'b0, 3'd2, 0);
        do_run(1'b0, 1'b1, 3'd6, 3 * ROWS + SETTLE + 1);
        do_run(1'b1, 1'b1, 3'd7, 0);

        // Abort on the 40th beat: reset and the beat arrive together.
        decision_in = 3'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i < 40; i++) begin
            in_data = DATA_W'(i);
            tick();
        end
        in_data = DATA_W'(40);
        rst = 1'b1;
        tick();
        check("abort_mat_sel", 32'(mat_sel), 32'd3);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result_valid", 32'(result_valid), 32'd0);
        check("abort_result_cleared", 32'(result), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_abort_mat_sel", 32'(mat_sel), 32'd3);
        check("post_abort_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();

        do_run(1'b0, 1'b0, 3'd1, 3 * ROWS + SETTLE + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ann_load_sequencer.md
Name: ann_load_sequencer

Overview:
Upstream driver for the ANN matrix core's load port (mat_sel / adr / write data) and consumer of its 3-bit decision output.
- Accepts a valid/ready word stream.
- Writes it row by row into the three core matrices: input, hidden weights, output weights.
- Waits a fixed settle time, then captures and holds the decision.
- Sits between the host/DMA word stream and the ANN core.

Parameters:
ROWS, 29, rows per matrix (row addresses 0..ROWS-1); must be <= 2**ADR_W
DATA_W, 21, width of one stream word / core write data
ADR_W, 5, width of the row address to the core
SETTLE_CYCLES, 2, cycles waited after the last write before decision is sampled (range 1..255)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  begin a load/evaluate run; sampled only in IDLE
in_valid  in  1  stream word valid
in_ready  out  1  sequencer can accept a word
in_data  in  DATA_W  stream word (signed)
mat_sel  out  2  core matrix select: 00 input, 01 hidden weights, 10 output weights, 11 no write
adr  out  ADR_W  core row address
w_data  out  DATA_W  core write data
decision_in  in  3  decision from core
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when result is captured
result  out  3  captured decision, held until next capture
result_valid  out  1  high from done until next accepted start

Behaviour:
- All outputs registered. Reset values: mat_sel=2'b11, adr=0, w_data=0, in_ready=0, busy=0, done=0, result=0, result_valid=0. FSM goes to IDLE; phase and row counters go to 0.
- The core writes on every clock where mat_sel != 11. mat_sel must therefore be 11 on every cycle without an accepted beat: in IDLE, SETTLE and CAPTURE, and on LOAD stall cycles.
- FSM states: IDLE, LOAD, SETTLE, CAPTURE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD; phase=0, row=0, busy=1, result_valid=0.
- LOAD:
  - in_ready=1 combinationally from state; it does not depend on in_valid.
  - Beat = in_valid & in_ready.
  - On a beat at cycle N: at N+1, mat_sel=phase, adr=row, w_data=in_data for exactly one cycle. Write latency is therefore 1.
  - Without a beat: mat_sel=11 next cycle; adr and w_data hold their last values.
  - Row counter increments per beat. At row==ROWS-1 it wraps to 0 and phase increments.
  - Beat with phase==2 and row==ROWS-1 -> SETTLE, counter=0. in_ready drops the cycle after that beat.
  - Back-to-back beats are legal: 3*ROWS beats in 3*ROWS consecutive cycles.
- SETTLE:
  - Counter starts at the first SETTLE cycle, i.e. the cycle the last write is presented.
  - Counts SETTLE_CYCLES cycles, then -> CAPTURE.
- CAPTURE (one cycle):
  - result<=decision_in, result_valid<=1, done pulses 1, busy<=0 -> IDLE.
  - done, result_valid and busy=0 all appear on the same cycle.
- start outside IDLE is ignored; it does not restart the run.
- start and a leftover in_valid in IDLE: the word is not accepted, because in_ready=0.
- rst mid-run, any state: abort. No further writes are issued, mat_sel=11 next cycle, state is as after reset. The previous result is cleared.
- Total run latency, no stalls: start at cycle 0 gives the first write at cycle 2 (first beat at cycle 1) and done at cycle 3*ROWS+SETTLE_CYCLES+1.

Optional Feature:
- Macro: ANN_LOAD_SEQ_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[15:0] (reset 0).
  - Cleared on accepted start.
  - On every beat, checksum <= checksum + in_data[15:0], mod 2^16.
  - Value is final and stable when done pulses; it holds until the next start.
- Undefined: no checksum port and no accumulator logic. All other behaviour is identical.

Test Plan:
- Reset then idle 10 cycles with in_valid=1 -> in_ready=0, mat_sel=11 every cycle, no writes.
- ROWS=29, start, 87 back-to-back words 1..87 -> the following, with no gaps:
  - mat_sel=00 for adr 0..28 carrying data 1..29.
  - mat_sel=01 carrying 30..58.
  - mat_sel=10 carrying 59..87.
  - decision_in=5 gives result=5 and done at cycle 3*29+2+1=90 after start.
- Random in_valid gaps (about 50%) -> mat_sel=11 on every gap cycle; final write sequence identical to the no-gap case.
- start pulsed during LOAD and SETTLE -> ignored. Row/phase progression unchanged, exactly one done.
- rst asserted at beat 40 -> no write the next cycle; busy=0, result_valid=0. A fresh run afterwards starts at mat_sel=00, adr=0.
- With ANN_LOAD_SEQ_CHECKSUM_EN: 87 words each 16'hFFFF -> checksum=(87*65535) mod 65536=16'hFFA9 at done.
